// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: PC-1 on load, one rotation step per
// round, combinational PC-2 of the C/D registers as the round key.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key,
  input  logic        next,
  output logic [1:48] Kn,
  output logic        valid,
  output logic [4:0]  round,
  output logic        last,
  output logic        busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [4:0]  round_q, round_d;
  logic        dir_q, dir_d;

  logic [1:56] pc1_cd;
  logic [1:56] cd_q;
  logic [4:0]  round_nxt;
  logic        one_step;

  function automatic logic [1:28] rot(
    input logic [1:28] v,
    input logic        left,
    input logic        two
  );
    logic [1:28] r;
    r = v;
    unique case (1'b1)
      ( left && !two): r = {v[2:28], v[1]};
      ( left &&  two): r = {v[3:28], v[1:2]};
      (!left && !two): r = {v[28], v[1:27]};
      (!left &&  two): r = {v[27:28], v[1:26]};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1_cd[g+1] = key[PC1[g]];
  end

  assign cd_q = {c_q, d_q};

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign Kn[g+1] = cd_q[PC2[g]];
  end

  // Rounds 2, 9 and 16 take a single-bit step in both directions
  assign round_nxt = round_q + 5'd1;
  assign one_step  = (round_nxt == 5'd2)
                   | (round_nxt == 5'd9)
                   | (round_nxt == 5'd16);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Decrypt starts at K16, which sits at zero net rotation
          c_d     = decrypt ? pc1_cd[1:28]
                            : rot(pc1_cd[1:28], 1'b1, 1'b0);
          d_d     = decrypt ? pc1_cd[29:56]
                            : rot(pc1_cd[29:56], 1'b1, 1'b0);
          dir_d   = decrypt;
          round_d = 5'd1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (next) begin
          if (round_q >= 5'd16) begin
            round_d = 5'd0;
            state_d = IDLE;
          end else begin
            c_d     = rot(c_q, ~dir_q, ~one_step);
            d_d     = rot(d_q, ~dir_q, ~one_step);
            round_d = round_nxt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

  assign valid = (state_q == ACTIVE);
  assign busy  = valid;
  assign round = round_q;
  assign last  = valid && (round_q == 5'd16);

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule against the FIPS example key
// and an independent cumulative-rotation subkey model.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [1:64] key;
  logic        next;
  logic [1:48] Kn;
  logic        valid;
  logic [4:0]  round;
  logic        last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] FIPS = 64'h133457799BBCDFF1;
  localparam logic [63:0] ALT  = 64'hDEADBEEF01234567;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                             1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .decrypt (decrypt),
    .key     (key),
    .next    (next),
    .Kn      (Kn),
    .valid   (valid),
    .round   (round),
    .last    (last),
    .busy    (busy)
  );

  // Encrypt subkey n from the total left rotation since PC-1
  function automatic logic [47:0] model_k(
    input logic [63:0] k,
    input int          n
  );
    logic [55:0] cd;
    logic [55:0] cd2;
    logic [27:0] c, d, cr, dr;
    logic [47:0] r;
    int tot;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    tot = 0;
    for (int i = 0; i < n; i++) tot += SH[i];
    tot = tot % 28;
    for (int j = 0; j < 28; j++) begin
      cr[27-j] = c[27-((j+tot)%28)];
      dr[27-j] = d[27-((j+tot)%28)];
    end
    cd2 = {cr, dr};
    for (int i = 0; i < 48; i++) r[47-i] = cd2[56-PC2[i]];
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_round(input string tag, input logic [63:0] k,
                           input logic dec, input int r);
    logic [47:0] ek;
    logic        lst;
    ek  = model_k(k, dec ? 17 - r : r);
    lst = (r == 16);
    chk($sformatf("%s_r%0d", tag, r),
        {9'd0, Kn, round, valid, last},
        {9'd0, ek, 5'(r), 1'b1, lst});
  endtask

  task automatic begin_sched(input logic [63:0] k, input logic dec);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    tick();
    start   = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {56'd0, valid, round, last, busy}, 64'd0);
  endtask

  logic [63:0] rk;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    next    = 1'b0;
    decrypt = 1'b0;
    key     = '0;
    #12;
    chk("reset", {Kn, round, valid, last, busy}, 64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk_idle("idle_after_reset");

    // Encrypt, FIPS key
    begin_sched(FIPS, 1'b0);
    next = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      chk_round("enc", FIPS, 1'b0, r);
      if (r == 1)  chk("enc_k1",  {16'd0, Kn}, 64'h1B02EFFC7072);
      if (r == 2)  chk("enc_k2",  {16'd0, Kn}, 64'h79AED9DBC9E5);
      if (r == 16) chk("enc_k16", {16'd0, Kn}, 64'hCB3D8B0E17F5);
      tick();
    end
    next = 1'b0;
    chk_idle("enc_done");

    // Decrypt, FIPS key
    begin_sched(FIPS, 1'b1);
    next = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      chk_round("dec", FIPS, 1'b1, r);
      if (r == 1)  chk("dec_k1",  {16'd0, Kn}, 64'hCB3D8B0E17F5);
      if (r == 15) chk("dec_k15", {16'd0, Kn}, 64'h79AED9DBC9E5);
      if (r == 16) chk("dec_k16", {16'd0, Kn}, 64'h1B02EFFC7072);
      tick();
    end
    next = 1'b0;
    chk_idle("dec_done");

    // Stall at round 5, then idle next pulse
    begin_sched(FIPS, 1'b0);
    next = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      chk_round("stall_pre", FIPS, 1'b0, r);
      tick();
    end
    next = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_round($sformatf("stall_hold%0d", i), FIPS, 1'b0, 5);
    end
    next = 1'b1;
    for (int r = 5; r <= 16; r++) begin
      chk_round("stall_post", FIPS, 1'b0, r);
      tick();
    end
    tick();
    next = 1'b0;
    tick();
    chk_idle("idle_next_ignored");

    // start while ACTIVE (with next) is ignored
    begin_sched(FIPS, 1'b0);
    next = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      chk_round("ign", FIPS, 1'b0, r);
      if (r == 7) begin
        start   = 1'b1;
        key     = ALT;
        decrypt = 1'b1;
      end
      tick();
      start = 1'b0;
    end

    // Back-to-back start with next also high in IDLE
    rk      = {$urandom, $urandom};
    start   = 1'b1;
    key     = rk;
    decrypt = 1'b0;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      chk_round("b2b", rk, 1'b0, r);
      tick();
    end
    next = 1'b0;
    chk_idle("b2b_done");

    // Asynchronous reset in the middle of round 9
    begin_sched(FIPS, 1'b0);
    next = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      chk_round("rst_pre", FIPS, 1'b0, r);
      tick();
    end
    next = 1'b0;
    chk_round("rst_pre", FIPS, 1'b0, 9);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async", {Kn, round, valid, last, busy}, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk_idle("rst_released");
    begin_sched(FIPS, 1'b0);
    chk_round("post_rst", FIPS, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES subkey generator, directly upstream of the DES round function.
- Loads a 64-bit key, applies PC-1, then produces one 48-bit round key Kn per round, K1..K16 for encryption or K16..K1 for decryption.
- Kn is advanced on a request/acknowledge handshake from the round controller.
- Kn feeds the round function's Kn input unchanged, in the same [1:48] bit numbering.

Parameters:
- None. DES constants PC-1, PC-2 and the shift schedule are fixed inside the block.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  one-cycle pulse; key and decrypt are valid and are loaded this cycle
- decrypt  input  1  sampled with start; 0 = K1..K16, 1 = K16..K1
- key  input  [1:64]  DES key, FIPS bit numbering; parity bits 8,16,..,64 are ignored
- next  input  1  consumer has used the current Kn; advance to the following round
- Kn  output  [1:48]  current round key, PC-2 of the C/D registers
- valid  output  1  Kn holds a valid round key
- round  output  [4:0]  1..16 while valid, 0 otherwise
- last  output  1  valid and round == 16
- busy  output  1  a schedule is in progress (equals valid)

Behaviour:
- State: C[1:28] and D[1:28] registers, round counter, dir flag, FSM {IDLE, ACTIVE}.
- Reset (async, rst_n=0): FSM=IDLE, C=D=0, round=0, dir=0. Outputs: valid=0, last=0, busy=0, Kn=PC2(0)=0.
- Reset asserted mid-schedule aborts it immediately; after release the block is IDLE.
- Kn is combinational PC-2 of the registered C,D, so it has no extra latency.
- Encrypt shift schedule (left rotate applied before Kn of round n, n=1..16): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt shift schedule (right rotate applied before Kn of round n, n=1..16): 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE + start=1 at edge t:
  - C,D <= PC1(key) rotated by round-1 amount (encrypt: left 1; decrypt: 0).
  - dir <= decrypt, round <= 1, FSM <= ACTIVE.
  - valid=1 from cycle t+1, so latency from start to K1 is one cycle.
- ACTIVE + next=1 + round<16: rotate C,D by the schedule amount for round+1 in direction dir; round <= round+1. Kn updates the next cycle.
- ACTIVE + next=1 + round==16: FSM <= IDLE, valid=0, round=0. C,D hold their last value, but Kn is don't-care while valid=0.
- ACTIVE + next=0: all state holds, so Kn is stable indefinitely (consumer may stall).
- next with valid=0 is ignored.
- start while ACTIVE is ignored, including in the same cycle as next; the current schedule continues.
- start and next together in IDLE: start wins; next is ignored.
- Back-to-back schedules: start may be accepted in the cycle after the final next. There is no dead cycle beyond that.
- Rotations are 28-bit circular, C and D independently. After a full encrypt schedule C,D have rotated by a total of 28, back to PC1(key).
- Width rules: round counter 5 bits; values 17..31 are unreachable, and if ever reached the FSM treats them as the round==16 case.

Test Plan:
- Encrypt, FIPS key 0x133457799BBCDFF1, decrypt=0, start pulse, then next every cycle -> Kn=0x1B02EFFC7072 at round 1, 0x79AED9DBC9E5 at round 2, 0xCB3D8B0E17F5 at round 16 with last=1. valid drops one cycle after the 16th next.
- Decrypt, same key, decrypt=1 -> round 1 Kn=0xCB3D8B0E17F5, round 15 Kn=0x79AED9DBC9E5, round 16 Kn=0x1B02EFFC7072. The full sequence must equal the encrypt sequence reversed.
- Stall: hold next=0 for 10 cycles at round 5 -> Kn and round stay constant; the sequence resumes correctly afterwards. Pulsing next while valid=0 changes nothing.
- Ignored start: assert start with a different key and decrypt=1 at round 7 -> rounds 8..16 still match the original key in encrypt order.
- Reset mid-operation: drop rst_n asynchronously (between clock edges) at round 9 -> valid=0, round=0, Kn=0 immediately. A new start after release produces K1 correctly.
- Back-to-back: issue start in the cycle after the 16th next, with a random key checked against a software model -> K1 valid on the following cycle and all 16 subkeys match the model.
